// File: rtl/fir3_input_packer.sv
`default_nettype none
// ============================================================================
// Module   : fir3_input_packer
// Purpose  : Packs a gapped serial sample stream into groups of three for the
//            3-way unfolded FIR, with zero-padded flush of a trailing group.
// Revision : 1.0 - initial release
// ============================================================================
module fir3_input_packer #(
  parameter int NB = 14
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [NB-1:0] DIN,
  input  logic          VIN,
  input  logic          FLUSH,
  output logic [NB-1:0] DOUT_3k,
  output logic [NB-1:0] DOUT_3k_1,
  output logic [NB-1:0] DOUT_3k_2,
  output logic          VOUT,
  output logic          BUSY
);

  typedef enum logic [1:0] {
    LANE0 = 2'd0,
    LANE1 = 2'd1,
    LANE2 = 2'd2
  } laneT;

  laneT          r_idx;
  logic [NB-1:0] r_stage0;
  logic [NB-1:0] r_stage1;
  logic [NB-1:0] r_lane0;
  logic [NB-1:0] r_lane1;
  logic [NB-1:0] r_lane2;
  logic          r_vout;
  logic          r_busy;

  laneT          w_nextIdx;
  logic [NB-1:0] w_stage0;
  logic [NB-1:0] w_stage1;
  logic          w_emit;
  logic [NB-1:0] w_lane0;
  logic [NB-1:0] w_lane1;
  logic [NB-1:0] w_lane2;

  // Capture first, then let FLUSH act on the post-capture state so a sample
  // arriving on the flush edge is included in the padded group.
  always_comb begin
    w_nextIdx = r_idx;
    w_stage0  = r_stage0;
    w_stage1  = r_stage1;
    w_emit    = 1'b0;
    w_lane0   = r_stage0;
    w_lane1   = r_stage1;
    w_lane2   = DIN;
    if (VIN) begin
      case (r_idx)
        LANE0: begin
          w_stage0  = DIN;
          w_nextIdx = LANE1;
        end
        LANE1: begin
          w_stage1  = DIN;
          w_nextIdx = LANE2;
        end
        LANE2: begin
          w_emit    = 1'b1;
          w_nextIdx = LANE0;
        end
        default: w_nextIdx = LANE0;
      endcase
    end
    if (FLUSH && (w_nextIdx != LANE0)) begin
      w_emit  = 1'b1;
      w_lane0 = w_stage0;
      w_lane1 = (w_nextIdx == LANE2) ? w_stage1 : '0;
      w_lane2 = '0;
      w_nextIdx = LANE0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_idx    <= LANE0;
      r_stage0 <= '0;
      r_stage1 <= '0;
      r_lane0  <= '0;
      r_lane1  <= '0;
      r_lane2  <= '0;
      r_vout   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_idx    <= w_nextIdx;
      r_stage0 <= w_stage0;
      r_stage1 <= w_stage1;
      r_vout   <= w_emit;
      r_busy   <= (w_nextIdx != LANE0);
      if (w_emit) begin
        r_lane0 <= w_lane0;
        r_lane1 <= w_lane1;
        r_lane2 <= w_lane2;
      end
    end
  end

  assign DOUT_3k   = r_lane0;
  assign DOUT_3k_1 = r_lane1;
  assign DOUT_3k_2 = r_lane2;
  assign VOUT      = r_vout;
  assign BUSY      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_fir3_input_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir3_input_packer
// Purpose  : Directed scoreboard bench for the serial-to-3-parallel packer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir3_input_packer;

  localparam int NB = 14;

  logic          clk;
  logic          rst;
  logic [NB-1:0] din;
  logic          vin;
  logic          flush;
  logic [NB-1:0] dout0;
  logic [NB-1:0] dout1;
  logic [NB-1:0] dout2;
  logic          vout;
  logic          busy;

  fir3_input_packer #(.NB(NB)) dut (
    .CLK       (clk),
    .RST       (rst),
    .DIN       (din),
    .VIN       (vin),
    .FLUSH     (flush),
    .DOUT_3k   (dout0),
    .DOUT_3k_1 (dout1),
    .DOUT_3k_2 (dout2),
    .VOUT      (vout),
    .BUSY      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [3*NB-1:0] expQ[$];
  logic [3*NB-1:0] lastGroup;
  int              mIdx;
  logic [NB-1:0]   mS0;
  logic [NB-1:0]   mS1;
  logic [NB-1:0]   counter;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock of stimulus; the reference model decides what should be emitted
  // and the DUT output is popped from the scoreboard when it strobes.
  task automatic step(input logic v, input logic [NB-1:0] d, input logic f);
    logic expV;
    @(negedge clk);
    vin = v; din = d; flush = f;
    @(posedge clk);
    expV = 1'b0;
    if (v) begin
      if (mIdx == 0) begin
        mS0 = d; mIdx = 1;
      end else if (mIdx == 1) begin
        mS1 = d; mIdx = 2;
      end else begin
        expQ.push_back({mS0, mS1, d}); mIdx = 0; expV = 1'b1;
      end
    end
    if (f && mIdx != 0) begin
      expQ.push_back({mS0, (mIdx == 2) ? mS1 : {NB{1'b0}}, {NB{1'b0}}});
      mIdx = 0;
      expV = 1'b1;
    end
    #1;
    check("vout", {63'd0, vout}, {63'd0, expV});
    if (vout === 1'b1) begin
      if (expQ.size() > 0) lastGroup = expQ.pop_front();
      else check("unexpected_group", 64'd1, 64'd0);
    end
    check("lanes", {22'd0, dout0, dout1, dout2}, {22'd0, lastGroup});
    check("busy", {63'd0, busy}, {63'd0, (mIdx != 0)});
    vin = 1'b0; flush = 1'b0;
  endtask

  task automatic resetModel();
    mIdx = 0; mS0 = '0; mS1 = '0; lastGroup = '0;
    expQ.delete();
  endtask

  initial begin
    rst = 1'b1; vin = 1'b0; din = '0; flush = 1'b0;
    resetModel();
    counter = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_lanes", {22'd0, dout0, dout1, dout2}, 64'd0);
    check("reset_vout", {63'd0, vout}, 64'd0);
    check("reset_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Continuous stream 1..6
    for (int i = 1; i <= 6; i++) step(1'b1, NB'(i), 1'b0);
    step(1'b0, '0, 1'b0);

    // Gapped stream: 6 low, 10 high, 4 low, 10 high, 8 low, 12 high
    begin
      int lens[6] = '{6, 10, 4, 10, 8, 12};
      for (int s = 0; s < 6; s++) begin
        for (int c = 0; c < lens[s]; c++) begin
          if (s % 2 == 1) begin
            counter = counter + 1'b1;
            step(1'b1, counter, 1'b0);
          end else begin
            step(1'b0, '0, 1'b0);
          end
        end
      end
    end
    // Realign to lane 0 with a flush if the gapped run left a partial group
    step(1'b0, '0, 1'b1);

    // Flush with two samples pending
    step(1'b1, 14'd7, 1'b0);
    step(1'b1, 14'd8, 1'b0);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);

    // Flush on the edge that captures the second sample, then idle flush
    step(1'b1, 14'h3FFB, 1'b0);
    step(1'b1, 14'd9, 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);

    // Flush with a single sample pending
    step(1'b1, 14'h0123, 1'b0);
    step(1'b0, '0, 1'b1);

    // Asynchronous reset mid-group
    step(1'b1, 14'd21, 1'b0);
    step(1'b1, 14'd22, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_lanes", {22'd0, dout0, dout1, dout2}, 64'd0);
    check("async_rst_vout", {63'd0, vout}, 64'd0);
    check("async_rst_busy", {63'd0, busy}, 64'd0);
    resetModel();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    step(1'b1, 14'hA, 1'b0);
    step(1'b1, 14'hB, 1'b0);
    step(1'b1, 14'hC, 1'b0);

    // Extreme bit patterns
    step(1'b1, 14'h1FFF, 1'b0);
    step(1'b1, 14'h2000, 1'b0);
    step(1'b1, 14'h3FFF, 1'b0);
    step(1'b0, '0, 1'b0);

    check("scoreboard_empty", 64'(expQ.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
